seq_pattern_gen: RTL and testbench
==================================

Name: seq_pattern_gen

Overview:
- Stimulus generator for the pattern a ##1 b[*B_REPS] ##1 c[*C_REPS] |-> d.
- Drives a, b, c and d with cycle-exact timing on request, with d overlapping the final c cycle.
- Sits in the bench and demo tops as the producer side of that pattern; the team's SVA checker observes its outputs.
- All outputs are registered.

Parameters:
- B_REPS, 2, consecutive cycles b is held high; must be >= 1 (elaboration-time check, fatal otherwise).
- C_REPS, 3, consecutive cycles c is held high; must be >= 1 (elaboration-time check).

Ports:
- clk  input  1  single clock, all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request one pattern; sampled on posedge.
- abort  input  1  synchronous cancel of the pattern in progress.
- a  output  1  high for exactly 1 cycle, the first pattern cycle.
- b  output  1  high for B_REPS consecutive cycles after a.
- c  output  1  high for C_REPS consecutive cycles after b.
- d  output  1  high in the final c cycle only.
- busy  output  1  high while a pattern is being driven (state != IDLE).
- done  output  1  one-cycle pulse coincident with d.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, rep counter = 0, all outputs 0. Release is synchronous to the next posedge.
- FSM states: IDLE, PH_A, PH_B, PH_C.
- Exactly one of a/b/c is high in PH_A/PH_B/PH_C respectively; none is high in IDLE.
- IDLE: start = 1 at edge k gives PH_A in cycle k+1, so a = 1 and busy = 1 one cycle after start. start = 0 stays in IDLE.
- PH_A: always goes to PH_B next cycle and loads the rep counter with 1.
- PH_B: counter increments each cycle. When counter == B_REPS, the next state is PH_C with the counter reloaded to 1.
- PH_C: counter increments each cycle.
  - When counter == C_REPS, this is the last c cycle: d = 1 and done = 1 in that same cycle.
  - Next state is IDLE, or PH_A if start = 1 in that last cycle (back-to-back, no gap cycle).
- Pattern length: 1 + B_REPS + C_REPS cycles. Defaults give 6 cycles: a, b, b, c, c, c, with d on cycle 6.
- start while busy, other than in the last PH_C cycle, is ignored (not queued).
- abort = 1 at an edge while busy: next cycle is IDLE with all outputs 0. No d and no done for that pattern.
- abort has priority over start at the same edge, including the back-to-back case.
- abort in IDLE has no effect.
- Counter width: $clog2(max(B_REPS, C_REPS) + 1). The counter never wraps, because the compare precedes overflow.
- Reset asserted mid-pattern: outputs drop to 0 immediately (asynchronously) and no done is produced.

Optional Feature:
- Macro: SEQ_GEN_ERR_INJECT_EN.
- When defined:
  - Adds input inject_err (1 bit), sampled together with an accepted start.
  - Adds output err_pending (1 bit), registered and high for the duration of the injected pattern.
  - An injected pattern is driven normally except that d stays 0 in the final c cycle; done still pulses.
  - The pattern is intended for negative testing of the checker.
  - err_pending clears on return to IDLE, on abort, and on reset.
- When not defined: neither port exists, and d always accompanies the final c.

Decomposition:
- Package seq_gen_pkg:
  - typedef enum logic [1:0] seq_state_t {IDLE, PH_A, PH_B, PH_C};
  - function cnt_width(b_reps, c_reps) returning the counter width.
- Sub-module seq_gen_rep_counter:
  - Load-to-1 / increment / terminal-compare counter, parameterised by width.
  - Inputs: load, inc, limit. Output: at_limit (combinational).
  - Instantiated once and shared by PH_B and PH_C.

Test Plan:
1. Defaults, start pulse at cycle 10 -> a@11; b@12-13; c@14-16; d and done@16; busy 11-16; IDLE@17.
2. start held high continuously -> patterns repeat every 6 cycles with no gap; a follows each d on the very next cycle; d count = number of completed patterns.
3. abort at the 2nd b cycle -> all outputs 0 the next cycle; no d/done; a later start yields a full, correct pattern.
4. start and abort together in the last PH_C cycle -> d and done still pulse that cycle; next cycle is IDLE (no new a).
5. Parameters B_REPS=1, C_REPS=1 -> a, b, c over 3 cycles with d on the c cycle; rst_n dropped mid-c -> outputs 0 asynchronously.
6. With SEQ_GEN_ERR_INJECT_EN, start and inject_err = 1 -> d = 0 on the final c cycle; done = 1; err_pending high for the 6 cycles; checker fires exactly once.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared state encoding and counter sizing for the pattern generator
package seq_gen_pkg;
  typedef enum logic [1:0] {IDLE, PH_A, PH_B, PH_C} seq_state_t;
  function automatic int cnt_width(input int b_reps, input int c_reps);
    return $clog2((b_reps > c_reps ? b_reps : c_reps) + 1);
  endfunction
endpackage

// File: rtl/seq_gen_rep_counter.sv
// seq_gen_rep_counter: load-to-1 / increment repetition counter with terminal compare
module seq_gen_rep_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic         at_limit
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (load) r_cnt <= W'(1);
    else if (inc) r_cnt <= r_cnt + W'(1);
  assign at_limit = r_cnt == limit;
endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: drives a ##1 b[*B_REPS] ##1 c[*C_REPS] |-> d with registered outputs
// Optional SEQ_GEN_ERR_INJECT_EN adds inject_err/err_pending to suppress d for negative tests.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int B_REPS = 2,
  parameter int C_REPS = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
`ifdef SEQ_GEN_ERR_INJECT_EN
  input  logic inject_err,
  output logic err_pending,
`endif
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic busy,
  output logic done
);
  localparam int W = cnt_width(B_REPS, C_REPS);
  localparam logic [W-1:0] LIM_B = W'(B_REPS);
  localparam logic [W-1:0] LIM_C = W'(C_REPS - 1);

  if (B_REPS < 1 || C_REPS < 1) begin : g_bad_params
    $fatal(1, "seq_pattern_gen: B_REPS and C_REPS must be >= 1");
  end

  seq_state_t r_state, w_nxt;
  logic r_a, r_b, r_c, r_d, r_busy, r_done;
  logic w_load, w_inc, w_at_limit, w_last_nxt, w_err_nxt;
  logic [W-1:0] w_limit;

  // In PH_C the counter is compared one short of C_REPS so the last-cycle flags can be registered.
  assign w_limit = r_state == PH_B ? LIM_B : LIM_C;

  always_comb begin
    w_nxt = r_state;
    w_load = 1'b0;
    w_inc = 1'b0;
    w_last_nxt = 1'b0;
    case (r_state)
      IDLE: w_nxt = start ? PH_A : IDLE;
      PH_A: begin
        w_nxt = abort ? IDLE : PH_B;
        w_load = 1'b1;
      end
      PH_B: begin
        w_nxt = abort ? IDLE : w_at_limit ? PH_C : PH_B;
        w_load = w_at_limit;
        w_inc = !w_at_limit;
        w_last_nxt = !abort && w_at_limit && C_REPS == 1;
      end
      PH_C: begin
        w_nxt = abort ? IDLE : r_done ? (start ? PH_A : IDLE) : PH_C;
        w_inc = !r_done;
        w_last_nxt = !abort && !r_done && w_at_limit;
      end
      default: w_nxt = IDLE;
    endcase
  end

  seq_gen_rep_counter #(.W(W)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_load),
    .inc     (w_inc),
    .limit   (w_limit),
    .at_limit(w_at_limit)
  );

`ifdef SEQ_GEN_ERR_INJECT_EN
  logic r_err;
  assign w_err_nxt = w_nxt == PH_A ? inject_err : (w_nxt == IDLE ? 1'b0 : r_err);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_err <= 1'b0;
    else r_err <= w_err_nxt;
  assign err_pending = r_err;
`else
  assign w_err_nxt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a <= 1'b0;
      r_b <= 1'b0;
      r_c <= 1'b0;
      r_d <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_a <= w_nxt == PH_A;
      r_b <= w_nxt == PH_B;
      r_c <= w_nxt == PH_C;
      r_d <= w_last_nxt && !w_err_nxt;
      r_busy <= w_nxt != IDLE;
      r_done <= w_last_nxt;
    end
  end

  assign a = r_a;
  assign b = r_b;
  assign c = r_c;
  assign d = r_d;
  assign busy = r_busy;
  assign done = r_done;
endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: directed table-driven bench for seq_pattern_gen (defaults and B_REPS=C_REPS=1)
module tb_seq_pattern_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b1, start = 1'b0, abort = 1'b0;
  logic rst1_n = 1'b1, start1 = 1'b0, abort1 = 1'b0;
  logic a, b, c, d, busy, done;
  logic a1, b1, c1, d1, busy1, done1;
`ifdef SEQ_GEN_ERR_INJECT_EN
  logic inj = 1'b0, inj1 = 1'b0, errp, errp1;
`endif
  int errs = 0, checks = 0;

  localparam logic [5:0] P_I = 6'b000000, P_A = 6'b100010, P_B = 6'b010010;
  localparam logic [5:0] P_C = 6'b001010, P_L = 6'b001111, P_X = 6'b001011;

  typedef struct packed {
    logic       st;
    logic       ab;
    logic [5:0] exp;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  seq_pattern_gen u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
`ifdef SEQ_GEN_ERR_INJECT_EN
    .inject_err(inj), .err_pending(errp),
`endif
    .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done)
  );

  seq_pattern_gen #(.B_REPS(1), .C_REPS(1)) u1 (
    .clk(clk), .rst_n(rst1_n), .start(start1), .abort(abort1),
`ifdef SEQ_GEN_ERR_INJECT_EN
    .inject_err(inj1), .err_pending(errp1),
`endif
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic st, input logic ab, input logic [5:0] exp);
    vec_t v;
    v.st = st;
    v.ab = ab;
    v.exp = exp;
    vecs.push_back(v);
  endfunction

  function automatic void add_full();
    add(1, 0, P_A); add(0, 0, P_B); add(0, 0, P_B);
    add(0, 0, P_C); add(0, 0, P_C); add(0, 0, P_L); add(0, 0, P_I);
  endfunction

  logic [5:0] phase[6];
  int dcnt;

  initial begin
    phase = '{P_A, P_B, P_B, P_C, P_C, P_L};
    // idle lead-in, then one plain pattern
    for (int i = 0; i < 6; i++) add(0, 0, P_I);
    add_full();
    // abort in IDLE is ignored; start alongside it is accepted; start while busy is ignored
    add(0, 1, P_I);
    add(1, 1, P_A); add(0, 0, P_B); add(1, 0, P_B);
    add(0, 0, P_C); add(1, 0, P_C); add(0, 0, P_L); add(0, 0, P_I);
    // abort at the second b cycle, then a full recovery pattern
    add(1, 0, P_A); add(0, 0, P_B); add(0, 0, P_B); add(0, 1, P_I); add(0, 0, P_I);
    add_full();
    // abort beats back-to-back start in the last c cycle
    add(1, 0, P_A); add(0, 0, P_B); add(0, 0, P_B);
    add(0, 0, P_C); add(0, 0, P_C); add(0, 0, P_L); add(1, 1, P_I); add(0, 0, P_I);
    // abort during the a cycle
    add(1, 0, P_A); add(0, 1, P_I); add(0, 0, P_I);

    #2;
    rst_n = 1'b0;
    rst1_n = 1'b0;
    step();
    chk("reset_u0", {a, b, c, d, busy, done}, P_I);
    chk("reset_u1", {a1, b1, c1, d1, busy1, done1}, P_I);
    rst_n = 1'b1;
    rst1_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].st;
      abort = vecs[i].ab;
      step();
      chk($sformatf("vec%0d", i), {a, b, c, d, busy, done}, vecs[i].exp);
    end

    // start held high: back-to-back patterns with no gap
    dcnt = 0;
    start = 1'b1;
    abort = 1'b0;
    for (int i = 0; i < 18; i++) begin
      step();
      dcnt += int'(d);
      chk($sformatf("b2b%0d", i), {a, b, c, d, busy, done}, phase[i % 6]);
    end
    start = 1'b0;
    step();
    chk("b2b_end", {a, b, c, d, busy, done}, P_I);
    chk("b2b_dcount", dcnt, 3);

`ifdef SEQ_GEN_ERR_INJECT_EN
    start = 1'b1;
    inj = 1'b1;
    step();
    chk("inj_a", {a, b, c, d, busy, done, errp}, {P_A, 1'b1});
    start = 1'b0;
    inj = 1'b0;
    dcnt = 0;
    for (int i = 1; i < 6; i++) begin
      step();
      dcnt += int'(d);
      chk($sformatf("inj%0d", i), {a, b, c, d, busy, done, errp}, {(i == 5 ? P_X : phase[i]), 1'b1});
    end
    step();
    chk("inj_idle", {a, b, c, d, busy, done, errp}, 7'b0);
    chk("inj_dcount", dcnt, 0);
    add_full();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i < 6; i++) step();
    chk("noinj_last", {a, b, c, d, busy, done, errp}, {P_L, 1'b0});
    step();
`endif

    // B_REPS=1, C_REPS=1: three-cycle pattern, then async reset during c
    start1 = 1'b1;
    step();
    chk("u1_a", {a1, b1, c1, d1, busy1, done1}, P_A);
    start1 = 1'b0;
    step();
    chk("u1_b", {a1, b1, c1, d1, busy1, done1}, P_B);
    step();
    chk("u1_c", {a1, b1, c1, d1, busy1, done1}, P_L);
    step();
    chk("u1_idle", {a1, b1, c1, d1, busy1, done1}, P_I);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    step();
    chk("u1_c2", {a1, b1, c1, d1, busy1, done1}, P_L);
    #2 rst1_n = 1'b0;
    #1;
    chk("u1_async_rst", {a1, b1, c1, d1, busy1, done1}, P_I);
    step();
    rst1_n = 1'b1;
    step();
    chk("u1_after_rst", {a1, b1, c1, d1, busy1, done1}, P_I);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
